cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
- Run/step sequencer for the CPU core.
- Replaces free-running clock division with a single-cycle clock-enable (cpu_en) on the fast system clock.
- Supports three modes: free-run at a programmable rate, single-step from a debounced push button, and latched halt on a CPU halt request.
- Sits between board switches/buttons and the CPU clock-enable input; exposes status for LEDs.

Parameters:
- DIV_W, 25, prescaler width; in RUN, one cpu_en pulse every 2^DIV_W clk cycles.
- DEB_W, 16, debounce counter width; an input must be stable 2^DEB_W cycles to be accepted.
- CNT_W, 16, width of tick_count.

Ports:
- clk  in  1  system clock (fast board clock).
- reset  in  1  synchronous, active-high reset.
- run_sw  in  1  raw asynchronous switch; 1 = free-run requested, 0 = step mode.
- step_btn  in  1  raw asynchronous push button, active-high.
- halt_req  in  1  synchronous level from the CPU (halt instruction retired).
- cpu_en  out  1  registered clock-enable to the CPU; high for exactly one clk cycle per CPU step.
- state  out  2  current FSM state: 00 STOPPED, 01 RUN, 10 STEP, 11 HALTED.
- tick_count  out  CNT_W  number of cpu_en pulses issued; wraps.

Behaviour:
- Reset (synchronous, one edge) clears everything:
  - state = STOPPED, cpu_en = 0, tick_count = 0, prescaler = 0.
  - Both 2-flop synchronisers = 0, debounced values = 0, debounce counters = 0.
- Reset has priority over all other inputs. Asserting reset mid-RUN or mid-STEP suppresses any pulse on the following cycle.
- Synchronisers: run_sw and step_btn each pass through 2 flops before debouncing.
- Debounce, one instance per input:
  - Counter clears whenever the synchronised value equals the debounced value.
  - While they differ, the counter increments.
  - When the counter = 2^DEB_W-1 and they still differ, the debounced value is updated and the counter cleared.
  - Giving run_db and btn_db.
- step_evt: a one-cycle pulse on a btn_db 0->1 transition. Falling edges are ignored.
- FSM, evaluated each clk edge; halt_req has highest priority after reset.
  - STOPPED:
    - halt_req=1 -> HALTED.
    - Else run_db=1 -> RUN, prescaler cleared.
    - Else step_evt=1 -> STEP, cpu_en<=1.
    - If run_db=1 and step_evt=1 in the same cycle, RUN wins and the step is dropped.
  - RUN:
    - halt_req=1 -> HALTED, no pulse.
    - Else run_db=0 -> STOPPED, no pulse, even if prescaler is at terminal count.
    - Else prescaler increments. When prescaler = 2^DIV_W-1: cpu_en<=1 for one cycle and prescaler wraps to 0.
    - step_evt is ignored.
  - STEP:
    - cpu_en is high during this single cycle.
    - Next state is HALTED if halt_req=1 (the pulse already issued stands), else STOPPED.
  - HALTED:
    - cpu_en = 0. run_sw and step_btn are ignored.
    - Exit only by reset.
- cpu_en is never high on two consecutive cycles unless DIV_W = 0, which is illegal (DIV_W >= 1).
- Latency:
  - step_evt in cycle N -> cpu_en high in cycle N+1.
  - Raw input change to debounced change = 2 sync cycles + 2^DEB_W cycles of stability.
- tick_count increments by 1 in every cycle cpu_en is high; wraps 2^CNT_W-1 -> 0.
- state output is the registered FSM state. No combinational path from any input to any output.

Test Plan:
1. DIV_W=4, DEB_W=3: reset, raise run_sw and hold.
   - After sync+debounce, state=01.
   - cpu_en pulses every 16 cycles, exactly 1 cycle wide.
   - After 5 pulses, tick_count=5.
2. DEB_W=3, run_sw=0: bounce step_btn (1 for 3 cycles, 0 for 2, then 1 for 20).
   - Exactly one cpu_en pulse, tick_count=1.
   - state sequence 00 -> 10 -> 00.
   - Glitches shorter than 8 stable cycles produce no pulse.
3. RUN with DIV_W=4: drop run_sw so run_db falls on the same cycle the prescaler hits 15.
   - No pulse; state=00.
   - Re-raising run_sw restarts the prescaler from 0 (first pulse 16 cycles after RUN entry).
4. Assert halt_req for one cycle during RUN, then during STEP.
   - RUN case: state=11 with no further pulses.
   - STEP case: the STEP pulse is still counted, then state=11.
   - In both cases, toggling run_sw/step_btn afterwards leaves cpu_en=0.
5. CNT_W=4: issue 17 pulses -> tick_count wraps and reads 1.
6. Assert reset for one cycle mid-RUN, one cycle before a terminal-count pulse.
   - No pulse follows.
   - All outputs read 0 (state=00) the cycle after reset.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/step/halt sequencer producing a single-cycle CPU clock-enable
module cpu_run_ctrl #(
    parameter int DIV_W = 25,
    parameter int DEB_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic             halt_req,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] tick_count
);
    typedef enum logic [1:0] {
        ST_STOPPED = 2'b00,
        ST_RUN     = 2'b01,
        ST_STEP    = 2'b10,
        ST_HALTED  = 2'b11
    } state_t;

    localparam logic [DEB_W-1:0] DEB_MAX = '1;
    localparam logic [DIV_W-1:0] DIV_MAX = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_run_s1;
    logic             r_run_s2;
    logic             r_btn_s1;
    logic             r_btn_s2;
    logic             r_run_db;
    logic             r_btn_db;
    logic             r_btn_db_d;
    logic [DEB_W-1:0] r_run_cnt;
    logic [DEB_W-1:0] r_btn_cnt;
    logic [DIV_W-1:0] r_presc;
    logic [DIV_W-1:0] w_presc_nxt;
    logic             r_cpu_en;
    logic             w_cpu_en_nxt;
    logic [CNT_W-1:0] r_tick;
    logic             w_step_evt;

    // Two-flop synchronisers feeding stability-counting debouncers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_run_s1   <= 1'b0;
            r_run_s2   <= 1'b0;
            r_btn_s1   <= 1'b0;
            r_btn_s2   <= 1'b0;
            r_run_db   <= 1'b0;
            r_btn_db   <= 1'b0;
            r_btn_db_d <= 1'b0;
            r_run_cnt  <= '0;
            r_btn_cnt  <= '0;
        end else begin
            r_run_s1   <= run_sw;
            r_run_s2   <= r_run_s1;
            r_btn_s1   <= step_btn;
            r_btn_s2   <= r_btn_s1;
            r_btn_db_d <= r_btn_db;

            if (r_run_s2 == r_run_db) begin
                r_run_cnt <= '0;
            end else if (r_run_cnt == DEB_MAX) begin
                r_run_db  <= r_run_s2;
                r_run_cnt <= '0;
            end else begin
                r_run_cnt <= r_run_cnt + 1'b1;
            end

            if (r_btn_s2 == r_btn_db) begin
                r_btn_cnt <= '0;
            end else if (r_btn_cnt == DEB_MAX) begin
                r_btn_db  <= r_btn_s2;
                r_btn_cnt <= '0;
            end else begin
                r_btn_cnt <= r_btn_cnt + 1'b1;
            end
        end
    end

    assign w_step_evt = r_btn_db & ~r_btn_db_d;

    always_comb begin
        w_state_nxt  = r_state;
        w_presc_nxt  = r_presc;
        w_cpu_en_nxt = 1'b0;
        case (r_state)
            ST_STOPPED: begin
                if (halt_req) begin
                    w_state_nxt = ST_HALTED;
                end else if (r_run_db) begin
                    w_state_nxt = ST_RUN;
                    w_presc_nxt = '0;
                end else if (w_step_evt) begin
                    w_state_nxt  = ST_STEP;
                    w_cpu_en_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                // A falling run switch beats a terminal-count pulse.
                if (halt_req) begin
                    w_state_nxt = ST_HALTED;
                end else if (!r_run_db) begin
                    w_state_nxt = ST_STOPPED;
                end else if (r_presc == DIV_MAX) begin
                    w_presc_nxt  = '0;
                    w_cpu_en_nxt = 1'b1;
                end else begin
                    w_presc_nxt = r_presc + 1'b1;
                end
            end
            ST_STEP: begin
                w_state_nxt = halt_req ? ST_HALTED : ST_STOPPED;
            end
            ST_HALTED: begin
                w_state_nxt = ST_HALTED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_STOPPED;
            r_presc  <= '0;
            r_cpu_en <= 1'b0;
            r_tick   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_presc  <= w_presc_nxt;
            r_cpu_en <= w_cpu_en_nxt;
            if (r_cpu_en) begin
                r_tick <= r_tick + 1'b1;
            end
        end
    end

    assign cpu_en     = r_cpu_en;
    assign state      = r_state;
    assign tick_count = r_tick;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - self-checking bench for cpu_run_ctrl with a cycle-level reference model
module tb_cpu_run_ctrl;
    localparam int DIV_W = 4;
    localparam int DEB_W = 3;
    localparam int CNT_W = 4;
    localparam int DIV_N = 1 << DIV_W;
    localparam int DEB_N = 1 << DEB_W;
    localparam int CNT_N = 1 << CNT_W;

    logic             clk;
    logic             reset;
    logic             run_sw;
    logic             step_btn;
    logic             halt_req;
    logic             cpu_en;
    logic [1:0]       state;
    logic [CNT_W-1:0] tick_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;
    int n_obs_pulse = 0;
    int n_obs_step  = 0;

    cpu_run_ctrl #(.DIV_W(DIV_W), .DEB_W(DEB_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .run_sw     (run_sw),
        .step_btn   (step_btn),
        .halt_req   (halt_req),
        .cpu_en     (cpu_en),
        .state      (state),
        .tick_count (tick_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: inputs delayed two samples, debounced when the last
    // DEB_N delayed samples since the previous change all disagree with the
    // accepted level; RUN pulses every DIV_N cycles counted from entry.
    int               m_state;
    bit               m_en;
    int               m_tick;
    int               m_run_cycles;
    logic [1:0]       m_run_raw, m_btn_raw;
    logic [DEB_N-1:0] m_run_hist, m_btn_hist;
    int               m_run_len, m_btn_len;
    logic             m_run_db, m_btn_db, m_btn_rise;
    int               st_n;
    bit               en_n;

    always @(posedge clk) begin
        if (reset) begin
            m_state = 0; m_en = 0; m_tick = 0; m_run_cycles = 0;
            m_run_raw = '0; m_btn_raw = '0; m_run_hist = '0; m_btn_hist = '0;
            m_run_len = 0; m_btn_len = 0; m_run_db = 0; m_btn_db = 0; m_btn_rise = 0;
        end else begin
            st_n = m_state;
            en_n = 0;
            case (m_state)
                0: if (halt_req) st_n = 3;
                   else if (m_run_db) begin st_n = 1; m_run_cycles = 0; end
                   else if (m_btn_rise) begin st_n = 2; en_n = 1; end
                1: if (halt_req) st_n = 3;
                   else if (!m_run_db) st_n = 0;
                   else begin
                       m_run_cycles++;
                       if (m_run_cycles % DIV_N == 0) en_n = 1;
                   end
                2: st_n = halt_req ? 3 : 0;
                default: st_n = 3;
            endcase
            if (m_en) m_tick = (m_tick + 1) % CNT_N;
            m_en = en_n;
            m_state = st_n;

            m_run_hist = {m_run_hist[DEB_N-2:0], m_run_raw[1]};
            m_run_raw  = {m_run_raw[0], run_sw};
            m_run_len++;
            if (m_run_len >= DEB_N && m_run_hist == {DEB_N{~m_run_db}}) begin
                m_run_db = ~m_run_db;
                m_run_len = 0;
            end

            m_btn_rise = 0;
            m_btn_hist = {m_btn_hist[DEB_N-2:0], m_btn_raw[1]};
            m_btn_raw  = {m_btn_raw[0], step_btn};
            m_btn_len++;
            if (m_btn_len >= DEB_N && m_btn_hist == {DEB_N{~m_btn_db}}) begin
                m_btn_db = ~m_btn_db;
                m_btn_rise = m_btn_db;
                m_btn_len = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if (cpu_en !== m_en || state !== m_state[1:0] || tick_count !== m_tick[CNT_W-1:0]) begin
                n_fail++;
                $display("FAIL model t=%0t: cpu_en=%0b want %0b state=%0d want %0d tick=%0d want %0d",
                         $time, cpu_en, m_en, state, m_state, tick_count, m_tick);
            end
            if (cpu_en === 1'b1) n_obs_pulse++;
            if (state === 2'b10) n_obs_step++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [1:0] target, input string name, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (state !== target && cyc < 200);
        check(name, {30'd0, state}, {30'd0, target});
    endtask

    task automatic wait_pulse(input string name, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (cpu_en !== 1'b1 && cyc < 200);
        check(name, {31'd0, cpu_en}, 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic hold_inputs(input logic r, input logic b, input int n);
        run_sw = r;
        step_btn = b;
        repeat (n) @(negedge clk);
    endtask

    int cyc;

    initial begin
        reset = 1'b1; run_sw = 1'b0; step_btn = 1'b0; halt_req = 1'b0;
        @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        reset = 1'b0;
        check("reset_state", {30'd0, state}, 32'd0);
        check("reset_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("reset_tick", {28'd0, tick_count}, 32'd0);

        // Free run: 2 sync + 8 debounce + 1 FSM cycles, then a pulse every 16.
        run_sw = 1'b1;
        wait_state(2'b01, "run_entry", cyc);
        check("run_entry_latency", cyc, 32'd11);
        for (int i = 0; i < 5; i++) begin
            wait_pulse("run_pulse", cyc);
            check("run_pulse_spacing", cyc, 32'd16);
        end
        @(negedge clk);
        check("run_tick5", {28'd0, tick_count}, 32'd5);

        // Drop run so the debounced level falls exactly at terminal count.
        wait_pulse("pre_drop_pulse", cyc);
        repeat (5) @(negedge clk);
        run_sw = 1'b0;
        repeat (11) @(negedge clk);
        check("drop_state", {30'd0, state}, 32'd0);
        check("drop_no_pulse", {31'd0, cpu_en}, 32'd0);
        repeat (5) @(negedge clk);
        check("drop_tick", {28'd0, tick_count}, 32'd6);
        run_sw = 1'b1;
        wait_state(2'b01, "rerun_entry", cyc);
        check("rerun_latency", cyc, 32'd11);
        wait_pulse("rerun_first_pulse", cyc);
        check("rerun_first_spacing", cyc, 32'd16);

        // Reset sampled on the terminal-count edge.
        wait_pulse("pre_reset_pulse", cyc);
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrun_reset_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("midrun_reset_state", {30'd0, state}, 32'd0);
        check("midrun_reset_tick", {28'd0, tick_count}, 32'd0);

        // Counter wrap after 17 pulses.
        wait_state(2'b01, "wrap_run_entry", cyc);
        for (int i = 0; i < 17; i++) wait_pulse("wrap_pulse", cyc);
        @(negedge clk);
        check("tick_wrap", {28'd0, tick_count}, 32'd1);

        // Bouncing step button: short glitch ignored, one clean press gives one step.
        run_sw = 1'b0;
        do_reset();
        n_obs_pulse = 0;
        n_obs_step = 0;
        hold_inputs(1'b0, 1'b1, 3);
        hold_inputs(1'b0, 1'b0, 2);
        repeat (10) @(negedge clk);
        check("glitch_no_pulse", n_obs_pulse, 32'd0);
        hold_inputs(1'b0, 1'b1, 20);
        hold_inputs(1'b0, 1'b0, 20);
        check("step_pulses", n_obs_pulse, 32'd1);
        check("step_state_cycles", n_obs_step, 32'd1);
        check("step_tick", {28'd0, tick_count}, 32'd1);
        check("step_back_stopped", {30'd0, state}, 32'd0);

        // Halt during RUN.
        run_sw = 1'b1;
        do_reset();
        wait_state(2'b01, "halt_run_entry", cyc);
        repeat (5) @(negedge clk);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        check("halt_run_state", {30'd0, state}, 32'd3);
        n_obs_pulse = 0;
        hold_inputs(1'b0, 1'b1, 15);
        hold_inputs(1'b1, 1'b0, 15);
        hold_inputs(1'b0, 1'b1, 15);
        check("halt_run_no_pulse", n_obs_pulse, 32'd0);
        check("halt_run_tick", {28'd0, tick_count}, 32'd0);
        check("halt_run_stays", {30'd0, state}, 32'd3);

        // Halt during STEP: the step pulse stands.
        hold_inputs(1'b0, 1'b0, 1);
        do_reset();
        step_btn = 1'b1;
        wait_state(2'b10, "halt_step_entry", cyc);
        check("halt_step_latency", cyc, 32'd11);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        check("halt_step_state", {30'd0, state}, 32'd3);
        n_obs_pulse = 0;
        hold_inputs(1'b0, 1'b0, 15);
        hold_inputs(1'b1, 1'b1, 15);
        check("halt_step_no_pulse", n_obs_pulse, 32'd0);
        check("halt_step_tick", {28'd0, tick_count}, 32'd1);
        check("halt_step_stays", {30'd0, state}, 32'd3);

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
